// File: rtl/prog_loader.sv
// Runtime program loader: turns a framed byte stream into RAM word writes and holds the CPU in reset meanwhile.
// Optional feature macro: LOADER_CHECKSUM_EN (trailing XOR checksum byte required and checked).
module prog_loader #(
    parameter int unsigned ADDR_W    = 11,
    parameter int unsigned DATA_W    = 32,
    parameter logic [7:0]  SYNC_BYTE = 8'hA5
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [7:0]        in_data,
    input  logic              in_valid,
    output logic              in_ready,
    output logic              mem_wr_en,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    output logic              cpu_rst_n,
    output logic [ADDR_W-1:0] start_pc,
    output logic              load_done,
    output logic              load_err
);

    localparam int unsigned CNT_W     = 16;
    localparam int unsigned MAX_WORDS = 2 ** ADDR_W;

    typedef enum logic [3:0] {
        IDLE, ADDR0, ADDR1, CNT0, CNT1, DATA, CSUM, DONE, ERR
    } state_t;

    state_t              state_q, state_nxt;
    logic [7:0]          addr_lo_q, addr_lo_nxt;
    logic [7:0]          cnt_lo_q, cnt_lo_nxt;
    logic [ADDR_W-1:0]   start_q, start_nxt;
    logic [ADDR_W-1:0]   wr_addr_q, wr_addr_nxt;
    logic [CNT_W-1:0]    words_left_q, words_left_nxt;
    logic [1:0]          byte_idx_q, byte_idx_nxt;
    logic [DATA_W-1:0]   shift_q, shift_nxt;
`ifdef LOADER_CHECKSUM_EN
    logic [7:0]          csum_q, csum_nxt;
`endif

    logic                mem_wr_en_nxt;
    logic [ADDR_W-1:0]   mem_addr_nxt;
    logic [DATA_W-1:0]   mem_wdata_nxt;
    logic                cpu_rst_n_nxt;
    logic [ADDR_W-1:0]   start_pc_nxt;
    logic                load_done_nxt;
    logic                load_err_nxt;

    logic                accept;
    logic                is_sync;
    logic [CNT_W-1:0]    cnt_full;

    assign accept   = in_valid & in_ready;
    assign is_sync  = (in_data == SYNC_BYTE);
    assign cnt_full = {in_data, cnt_lo_q};

    // State and output registers
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            addr_lo_q    <= '0;
            cnt_lo_q     <= '0;
            start_q      <= '0;
            wr_addr_q    <= '0;
            words_left_q <= '0;
            byte_idx_q   <= '0;
            shift_q      <= '0;
`ifdef LOADER_CHECKSUM_EN
            csum_q       <= '0;
`endif
            in_ready     <= 1'b0;
            mem_wr_en    <= 1'b0;
            mem_addr     <= '0;
            mem_wdata    <= '0;
            cpu_rst_n    <= 1'b0;
            start_pc     <= '0;
            load_done    <= 1'b0;
            load_err     <= 1'b0;
        end else begin
            state_q      <= state_nxt;
            addr_lo_q    <= addr_lo_nxt;
            cnt_lo_q     <= cnt_lo_nxt;
            start_q      <= start_nxt;
            wr_addr_q    <= wr_addr_nxt;
            words_left_q <= words_left_nxt;
            byte_idx_q   <= byte_idx_nxt;
            shift_q      <= shift_nxt;
`ifdef LOADER_CHECKSUM_EN
            csum_q       <= csum_nxt;
`endif
            in_ready     <= 1'b1;
            mem_wr_en    <= mem_wr_en_nxt;
            mem_addr     <= mem_addr_nxt;
            mem_wdata    <= mem_wdata_nxt;
            cpu_rst_n    <= cpu_rst_n_nxt;
            start_pc     <= start_pc_nxt;
            load_done    <= load_done_nxt;
            load_err     <= load_err_nxt;
        end
    end

    // Frame parser: next state and next output values
    always_comb begin
        state_nxt      = state_q;
        addr_lo_nxt    = addr_lo_q;
        cnt_lo_nxt     = cnt_lo_q;
        start_nxt      = start_q;
        wr_addr_nxt    = wr_addr_q;
        words_left_nxt = words_left_q;
        byte_idx_nxt   = byte_idx_q;
        shift_nxt      = shift_q;
`ifdef LOADER_CHECKSUM_EN
        csum_nxt       = csum_q;
`endif
        mem_wr_en_nxt  = 1'b0;
        mem_addr_nxt   = mem_addr;
        mem_wdata_nxt  = mem_wdata;
        cpu_rst_n_nxt  = cpu_rst_n;
        start_pc_nxt   = start_pc;
        load_done_nxt  = load_done;
        load_err_nxt   = load_err;

        case (state_q)
            IDLE: begin
                if (accept && is_sync) begin
                    state_nxt     = ADDR0;
                    cpu_rst_n_nxt = 1'b0;
                end
            end
            ADDR0: begin
                if (accept) begin
                    addr_lo_nxt = in_data;
                    state_nxt   = ADDR1;
                end
            end
            ADDR1: begin
                if (accept) begin
                    start_nxt = ADDR_W'({in_data, addr_lo_q});
                    state_nxt = CNT0;
                end
            end
            CNT0: begin
                if (accept) begin
                    cnt_lo_nxt = in_data;
                    state_nxt  = CNT1;
                end
            end
            CNT1: begin
                if (accept) begin
                    wr_addr_nxt    = start_q;
                    words_left_nxt = cnt_full;
                    byte_idx_nxt   = 2'd0;
`ifdef LOADER_CHECKSUM_EN
                    csum_nxt       = 8'h00;
`endif
                    if (32'(cnt_full) > MAX_WORDS) begin
                        state_nxt     = ERR;
                        load_err_nxt  = 1'b1;
                        load_done_nxt = 1'b0;
                        cpu_rst_n_nxt = 1'b0;
                    end else if (cnt_full == '0) begin
`ifdef LOADER_CHECKSUM_EN
                        state_nxt     = CSUM;
`else
                        state_nxt     = DONE;
                        cpu_rst_n_nxt = 1'b1;
                        start_pc_nxt  = start_q;
                        load_done_nxt = 1'b1;
                        load_err_nxt  = 1'b0;
`endif
                    end else begin
                        state_nxt = DATA;
                    end
                end
            end
            DATA: begin
                if (accept) begin
                    shift_nxt    = {in_data, shift_q[DATA_W-1:8]};
                    byte_idx_nxt = byte_idx_q + 2'd1;
`ifdef LOADER_CHECKSUM_EN
                    csum_nxt     = csum_q ^ in_data;
`endif
                    // Fourth byte completes the word: write it and advance the wrapping address
                    if (byte_idx_q == 2'd3) begin
                        mem_wr_en_nxt  = 1'b1;
                        mem_addr_nxt   = wr_addr_q;
                        mem_wdata_nxt  = {in_data, shift_q[DATA_W-1:8]};
                        wr_addr_nxt    = wr_addr_q + ADDR_W'(1);
                        words_left_nxt = words_left_q - CNT_W'(1);
                        if (words_left_q == CNT_W'(1)) begin
`ifdef LOADER_CHECKSUM_EN
                            state_nxt     = CSUM;
`else
                            state_nxt     = DONE;
                            cpu_rst_n_nxt = 1'b1;
                            start_pc_nxt  = start_q;
                            load_done_nxt = 1'b1;
                            load_err_nxt  = 1'b0;
`endif
                        end
                    end
                end
            end
`ifdef LOADER_CHECKSUM_EN
            CSUM: begin
                if (accept) begin
                    if (in_data == csum_q) begin
                        state_nxt     = DONE;
                        cpu_rst_n_nxt = 1'b1;
                        start_pc_nxt  = start_q;
                        load_done_nxt = 1'b1;
                        load_err_nxt  = 1'b0;
                    end else begin
                        state_nxt     = ERR;
                        load_err_nxt  = 1'b1;
                        load_done_nxt = 1'b0;
                        cpu_rst_n_nxt = 1'b0;
                    end
                end
            end
`endif
            DONE, ERR: begin
                if (accept && is_sync) begin
                    state_nxt     = ADDR0;
                    load_done_nxt = 1'b0;
                    load_err_nxt  = 1'b0;
                    cpu_rst_n_nxt = 1'b0;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

endmodule

// File: tb/tb_prog_loader.sv
// Directed self-checking bench for prog_loader; covers both LOADER_CHECKSUM_EN builds.
module tb_prog_loader;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [7:0]  in_data;
    logic        in_valid;
    logic        in_ready;
    logic        mem_wr_en;
    logic [10:0] mem_addr;
    logic [31:0] mem_wdata;
    logic        cpu_rst_n;
    logic [10:0] start_pc;
    logic        load_done;
    logic        load_err;

    int checks   = 0;
    int failures = 0;

    logic [10:0] wa_q[$];
    logic [31:0] wd_q[$];
    logic [7:0]  tb_csum;

    prog_loader dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_data   (in_data),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .mem_wr_en (mem_wr_en),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .cpu_rst_n (cpu_rst_n),
        .start_pc  (start_pc),
        .load_done (load_done),
        .load_err  (load_err)
    );

    always #5 clk = ~clk;

    // Log every RAM write strobe, sampled mid-cycle
    always @(negedge clk) begin
        if (mem_wr_en === 1'b1) begin
            wa_q.push_back(mem_addr);
            wd_q.push_back(mem_wdata);
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic send_byte(input logic [7:0] b, input int gap);
        in_data  = b;
        in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        repeat (gap) @(negedge clk);
    endtask

    task automatic send_header(input logic [15:0] addr, input logic [15:0] cnt, input int gap);
        send_byte(8'hA5, gap);
        send_byte(addr[7:0], gap);
        send_byte(addr[15:8], gap);
        send_byte(cnt[7:0], gap);
        send_byte(cnt[15:8], gap);
        tb_csum = 8'h00;
    endtask

    task automatic send_word(input logic [31:0] w, input int gap);
        for (int i = 0; i < 4; i++) begin
            send_byte(w[8*i +: 8], gap);
            tb_csum = tb_csum ^ w[8*i +: 8];
        end
    endtask

    task automatic send_csum(input logic [7:0] mask);
`ifdef LOADER_CHECKSUM_EN
        send_byte(tb_csum ^ mask, 0);
`else
        if (mask != 8'h00) $display("note: checksum byte not part of frame in this build");
`endif
    endtask

    task automatic settle();
        repeat (3) @(negedge clk);
    endtask

    task automatic clear_log();
        wa_q.delete();
        wd_q.delete();
    endtask

    task automatic check_reset_values(input string tag);
        check({tag, "_in_ready"},  32'(in_ready),  32'h0);
        check({tag, "_wr_en"},     32'(mem_wr_en), 32'h0);
        check({tag, "_mem_addr"},  32'(mem_addr),  32'h0);
        check({tag, "_mem_wdata"}, mem_wdata,      32'h0);
        check({tag, "_cpu_rst_n"}, 32'(cpu_rst_n), 32'h0);
        check({tag, "_start_pc"},  32'(start_pc),  32'h0);
        check({tag, "_done"},      32'(load_done), 32'h0);
        check({tag, "_err"},       32'(load_err),  32'h0);
    endtask

    task automatic do_reset(input string tag);
        rst_n    = 1'b0;
        in_valid = 1'b0;
        repeat (3) @(negedge clk);
        check_reset_values(tag);
        rst_n = 1'b1;
        @(negedge clk);
        check({tag, "_ready_after"}, 32'(in_ready), 32'h1);
    endtask

    task automatic check_done(input string tag, input logic [10:0] pc);
        check({tag, "_done"},      32'(load_done), 32'h1);
        check({tag, "_err"},       32'(load_err),  32'h0);
        check({tag, "_cpu_rst_n"}, 32'(cpu_rst_n), 32'h1);
        check({tag, "_start_pc"},  32'(start_pc),  32'(pc));
    endtask

    task automatic check_err(input string tag);
        check({tag, "_done"},      32'(load_done), 32'h0);
        check({tag, "_err"},       32'(load_err),  32'h1);
        check({tag, "_cpu_rst_n"}, 32'(cpu_rst_n), 32'h0);
    endtask

    task automatic check_two_writes(input string tag, input logic [10:0] a0, input logic [10:0] a1);
        check({tag, "_nwr"}, 32'(wa_q.size()), 32'd2);
        if (wa_q.size() == 2) begin
            check({tag, "_addr0"}, 32'(wa_q[0]), 32'(a0));
            check({tag, "_data0"}, wd_q[0],      32'hE3A01005);
            check({tag, "_addr1"}, 32'(wa_q[1]), 32'(a1));
            check({tag, "_data1"}, wd_q[1],      32'hE2811001);
        end
    endtask

    task automatic t1_frame(input logic [15:0] addr, input int gap);
        send_header(addr, 16'd2, gap);
        send_word(32'hE3A01005, gap);
        send_word(32'hE2811001, gap);
        send_csum(8'h00);
        settle();
    endtask

    initial begin
        rst_n    = 1'b0;
        in_valid = 1'b0;
        in_data  = 8'h00;
        tb_csum  = 8'h00;
        @(negedge clk);

        do_reset("rst");

        // T1: basic two-word load
        clear_log();
        t1_frame(16'h0010, 0);
        check_two_writes("t1", 11'h010, 11'h011);
        check_done("t1", 11'h010);

        // T2: garbage while DONE is discarded, then a gapped reload
        clear_log();
        send_byte(8'h00, 0);
        send_byte(8'hFF, 1);
        send_byte(8'h5A, 0);
        settle();
        check("t2_garbage_nwr", 32'(wa_q.size()), 32'd0);
        check_done("t2_garbage", 11'h010);
        send_byte(8'hA5, 0);
        check("t2_sync_cpu_rst_n", 32'(cpu_rst_n), 32'h0);
        check("t2_sync_done",      32'(load_done), 32'h0);
        send_byte(8'h10, 2);
        send_byte(8'h00, 2);
        send_byte(8'h02, 2);
        send_byte(8'h00, 2);
        tb_csum = 8'h00;
        send_word(32'hE3A01005, 3);
        send_word(32'hE2811001, 3);
        send_csum(8'h00);
        settle();
        check_two_writes("t2", 11'h010, 11'h011);
        check_done("t2", 11'h010);

        // T3: address wrap, upper address bits ignored
        clear_log();
        t1_frame(16'hF7FF, 0);
        check_two_writes("t3", 11'h7FF, 11'h000);
        check_done("t3", 11'h7FF);

`ifdef LOADER_CHECKSUM_EN
        // T4: bad checksum keeps written words, then recovers
        clear_log();
        send_header(16'h0010, 16'd2, 0);
        send_word(32'hE3A01005, 0);
        send_word(32'hE2811001, 0);
        send_csum(8'h01);
        settle();
        check_two_writes("t4", 11'h010, 11'h011);
        check_err("t4");
        clear_log();
        t1_frame(16'h0020, 0);
        check_two_writes("t4_reload", 11'h020, 11'h021);
        check_done("t4_reload", 11'h020);
`endif

        // T5a: oversize count errors immediately with no writes
        clear_log();
        send_header(16'h0000, 16'h0801, 0);
        settle();
        check_err("t5_over");
        send_byte(8'h11, 0);
        settle();
        check("t5_over_nwr", 32'(wa_q.size()), 32'd0);
        check("t5_over_hold_err", 32'(load_err), 32'h1);

        // T5b + T6: count of exactly 2**ADDR_W is legal; reset mid-word abandons it
        clear_log();
        send_header(16'h0000, 16'h0800, 0);
        settle();
        check("t5_max_err", 32'(load_err), 32'h0);
        send_byte(8'h05, 0);
        send_byte(8'h10, 0);
        do_reset("t6");
        check("t6_nwr", 32'(wa_q.size()), 32'd0);
        send_byte(8'h00, 0);
        send_byte(8'hFF, 0);
        send_byte(8'h5A, 0);
        settle();
        check("t6_idle_garbage_nwr", 32'(wa_q.size()), 32'd0);
        check("t6_idle_garbage_done", 32'(load_done), 32'h0);
        t1_frame(16'h0010, 0);
        check_two_writes("t6_reload", 11'h010, 11'h011);
        check_done("t6_reload", 11'h010);

        // T5c: zero-length frame
        clear_log();
        send_header(16'h0234, 16'h0000, 0);
        send_csum(8'h00);
        settle();
        check("t5_zero_nwr", 32'(wa_q.size()), 32'd0);
        check_done("t5_zero", 11'h234);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
